// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered DATA_WIDTH-wide ALU.
// Optional feature macro: ALU_MUL_EN adds an iterative shift-add multiplier
// (opcode 1011). Without it, 1011 is treated as an illegal opcode.
//
// state | meaning
// IDLE  | ready to accept an operation
// BUSY  | multiplier iterating (ALU_MUL_EN only)
// DONE  | result/flags valid, waiting for out_ready
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1011;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t state, state_next;
  logic   accept;

  logic                  is_sub;
  logic [DATA_WIDTH-1:0] b_x;
  logic [DATA_WIDTH:0]   sum_ext;
  logic                  sum_ov;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ov;
  logic                  alu_co;

`ifdef ALU_MUL_EN
  logic [SHAMT_W-1:0]    cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  is_mul;
  logic                  last_iter;

  assign is_mul    = (ALUop == OP_MUL);
  assign last_iter = (cnt == SHAMT_W'(DATA_WIDTH - 1));
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
`endif

  assign accept = in_valid && in_ready;
  assign Zero   = (Result == '0);
  assign shamt  = B[SHAMT_W-1:0];

  // Single adder shared by ADD, SUB and both compares (subtract mode = A + ~B + 1).
  always_comb begin
    is_sub  = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
    b_x     = is_sub ? ~B : B;
    sum_ext = {1'b0, A} + {1'b0, b_x} + {{DATA_WIDTH{1'b0}}, is_sub};
    sum_ov  = (A[DATA_WIDTH-1] == b_x[DATA_WIDTH-1]) &&
              (sum_ext[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
  end

  // Opcode decode into the value captured at accept; illegal codes give zero.
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_co  = 1'b0;
    case (ALUop)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_ADD: begin
        alu_res = sum_ext[DATA_WIDTH-1:0];
        alu_ov  = sum_ov;
        alu_co  = sum_ext[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_res = sum_ext[DATA_WIDTH-1:0];
        alu_ov  = sum_ov;
        alu_co  = ~sum_ext[DATA_WIDTH];
      end
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, sum_ext[DATA_WIDTH-1] ^ sum_ov};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, ~sum_ext[DATA_WIDTH]};
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef ALU_MUL_EN
          state_next = is_mul ? BUSY : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef ALU_MUL_EN
      BUSY: if (last_iter) state_next = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result/flag registers and multiplier datapath; held untouched while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      Result   <= '0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
`ifdef ALU_MUL_EN
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        Overflow <= 1'b0;
        CarryOut <= 1'b0;
        cnt      <= '0;
        acc      <= '0;
        mcand    <= A;
        mplier   <= B;
      end else if (accept) begin
        Result   <= alu_res;
        Overflow <= alu_ov;
        CarryOut <= alu_co;
      end else if (state == BUSY) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last_iter) Result <= acc_next;
      end
`else
      if (accept) begin
        Result   <= alu_res;
        Overflow <= alu_ov;
        CarryOut <= alu_co;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (DATA_WIDTH = 32): directed vector table,
// hand-written multi-cycle sequences and randomized ops against a reference model.
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALUop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Overflow;
  logic         CarryOut;
  logic         Zero;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ov;
    logic        co;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        co;
  } model_t;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode definitions, using wide signed arithmetic.
  function automatic model_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    model_t m;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sr;
    logic [4:0] sh = b[4:0];
    m.res = '0; m.ov = 1'b0; m.co = 1'b0;
    case (op)
      4'd0:  m.res = a & b;
      4'd1:  m.res = a | b;
      4'd2: begin
        m.res = a + b;
        sr = sa + sb;
        m.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        m.co = (ua + ub) > 64'sd4294967295;
      end
      4'd3:  m.res = a ^ b;
      4'd4:  m.res = ~(a | b);
      4'd5:  m.res = (a < b) ? 32'd1 : 32'd0;
      4'd6: begin
        m.res = a - b;
        sr = sa - sb;
        m.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        m.co = (a < b);
      end
      4'd7:  m.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  m.res = a << sh;
      4'd9:  m.res = a >> sh;
      4'd10: m.res = 32'($signed(a) >>> sh);
      4'd11: m.res = MUL_EN ? a * b : 32'd0;
      default: m.res = '0;
    endcase
    return m;
  endfunction

  // One complete transaction: accept, wait for result, check, then release it.
  task automatic do_op(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] er, logic eov, logic eco);
    int lat;
    int exp_lat;
    exp_lat = (MUL_EN && op == 4'd11) ? W + 1 : 1;
    chk({name, ".in_ready"}, in_ready, 1);
    A = a; B = b; ALUop = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUop = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      chk({name, ".busy_in_ready"}, in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".latency"}, lat, exp_lat);
    chk({name, ".res"}, Result, er);
    chk({name, ".ov"}, Overflow, eov);
    chk({name, ".co"}, CarryOut, eco);
    chk({name, ".zero"}, Zero, (er == 32'd0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, ".drop"}, out_valid, 0);
  endtask

  vec_t vecs[$];
  model_t m;

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    A = 32'd5; B = 32'd6; ALUop = 4'd2;

    vecs.push_back('{"add_ovf",  4'd2,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0});
    vecs.push_back('{"add_wrap", 4'd2,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b1});
    vecs.push_back('{"sub_brw",  4'd6,  32'h1,        32'h2,        32'hFFFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{"sub_ovf",  4'd6,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{"slt",      4'd7,  32'h80000000, 32'h1,        32'h1,        1'b0, 1'b0});
    vecs.push_back('{"sltu",     4'd5,  32'h80000000, 32'h1,        32'h0,        1'b0, 1'b0});
    vecs.push_back('{"sra",      4'd10, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1'b0});
    vecs.push_back('{"sll",      4'd8,  32'h1,        32'd31,       32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{"srl",      4'd9,  32'h80000000, 32'h4,        32'h08000000, 1'b0, 1'b0});
    vecs.push_back('{"and",      4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
    vecs.push_back('{"or",       4'd1,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
    vecs.push_back('{"xor",      4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0});
    vecs.push_back('{"nor",      4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0});
    vecs.push_back('{"illegal",  4'd12, 32'h12345678, 32'h9,        32'h0,        1'b0, 1'b0});
`ifdef ALU_MUL_EN
    vecs.push_back('{"mul",      4'd11, 32'hFFFFFFFF, 32'h3,        32'hFFFFFFFD, 1'b0, 1'b0});
`else
    vecs.push_back('{"mul_off",  4'd11, 32'hFFFFFFFF, 32'h3,        32'h0,        1'b0, 1'b0});
`endif

    // Reset with in_valid high: nothing may be accepted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst.post_in_ready", in_ready, 1);
    chk("rst.post_out_valid", out_valid, 0);
    chk("rst.result", Result, 0);
    chk("rst.zero", Zero, 1);
    chk("rst.ov", Overflow, 0);
    chk("rst.co", CarryOut, 0);

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].ov, vecs[i].co);

    // Back-pressure: result held, in_valid ignored, no accept on the release cycle.
    A = 32'd5; B = 32'd6; ALUop = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'd100; B = 32'd1; ALUop = 4'd6;
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      chk("bp.result", Result, 32'd11);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp.release_out_valid", out_valid, 0);
    chk("bp.release_in_ready", in_ready, 1);
    chk("bp.release_result", Result, 32'd11);

    // Reset while a result is waiting in DONE.
    A = 32'd7; B = 32'd0; ALUop = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_done.pre", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_done.out_valid", out_valid, 0);
    chk("rst_done.result", Result, 0);
    chk("rst_done.in_ready", in_ready, 1);

`ifdef ALU_MUL_EN
    // Reset at multiplier iteration 10: abort, no result ever appears.
    A = 32'hFFFFFFFF; B = 32'h3; ALUop = 4'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mul.busy", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mul.in_ready", in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) chk("rst_mul.stray_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    chk("rst_mul.result", Result, 0);
`endif

    // Randomized operations against the model, biased towards corner operands.
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = b;
        3: a = 32'h7FFFFFFF;
        default: ;
      endcase
      m = model(op, a, b);
      do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, m.res, m.ov, m.co);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
